// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared width, reset PC and state encoding for the PC sequencer
package pc_sequencer_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = '0;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/status bundle between fetch control and the PC sequencer
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] branch_target;
    logic             halt;
    logic             resume;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus1;
    logic             fetch_valid;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_overflow;
    logic             ras_underflow;

    modport master (
        output stall, branch_taken, call, ret, branch_target, halt, resume,
        input  pc, pc_plus1, fetch_valid, ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, branch_taken, call, ret, branch_target, halt, resume,
        output pc, pc_plus1, fetch_valid, ras_empty, ras_full, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_sequencer_inc.sv
// rtl/pc_sequencer_inc.sv - word-address PC incrementer, wraps modulo 2^WIDTH
module pc_sequencer_inc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + WIDTH'(1);
endmodule

// File: rtl/pc_sequencer_ras_stack.sv
// rtl/pc_sequencer_ras_stack.sv - circular return-address stack; push+pop together replaces the top
module pc_sequencer_ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign top_data = mem_q[top_q];

    always_comb begin
        mem_d     = mem_q;
        top_d     = top_q;
        cnt_d     = cnt_q;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (push && pop) begin
            if (empty) underflow = 1'b1;
            else       mem_d[top_q] = push_data;
        end else if (push) begin
            // When full, the slot after top is the oldest entry, so it is overwritten in place.
            top_d        = top_q + PTR_W'(1);
            mem_d[top_d] = push_data;
            if (full) overflow = 1'b1;
            else      cnt_d = cnt_q + CNT_W'(1);
        end else if (pop) begin
            if (empty) begin
                underflow = 1'b1;
            end else begin
                top_d = top_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC register, next-PC selection, RAS and boot/run/halt tracking
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int               RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);
    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus1;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ras_push, ras_pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty, ras_full, ras_ovf_pulse, ras_unf_pulse;

    pc_sequencer_inc #(.WIDTH(WIDTH)) u_inc (
        .a   (pc_q),
        .sum (pc_plus1)
    );

    pc_sequencer_ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus1),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_ovf_pulse),
        .underflow (ras_unf_pulse)
    );

    // halt outranks stall and every redirect: the halting edge leaves pc and RAS untouched.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.halt) begin
                    state_d = ST_HALTED;
                end else if (!bus.stall) begin
                    ras_push = bus.call;
                    ras_pop  = bus.ret;
                    if (bus.ret)                           pc_d = ras_empty ? pc_plus1 : ras_top;
                    else if (bus.call || bus.branch_taken) pc_d = bus.branch_target;
                    else                                   pc_d = pc_plus1;
                end
            end
            ST_HALTED: if (bus.resume) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    assign ovf_d = ovf_q | ras_ovf_pulse;
    assign unf_d = unf_q | ras_unf_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus1      = pc_plus1;
    assign bus.fetch_valid   = (state_q == ST_RUN);
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter register and next-PC sequencer for the KGP-miniRISC fetch stage. It consumes the +1 increment (word-addressed PC) and chooses the next PC from sequential, branch/jump, call and return sources. A small hardware return-address stack (RAS) supplies return targets. It also tracks boot, run and halt state so fetch knows when its address is valid.

Parameters:
WIDTH, 32, PC and address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
RAS_DEPTH, 4, number of return-address stack entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and RAS this cycle
branch_taken  in  1  redirect to branch_target (conditional/unconditional branch)
call  in  1  branch-and-link: redirect to branch_target, push pc+1
ret  in  1  return: redirect to RAS top, pop
branch_target  in  WIDTH  redirect address for branch_taken/call
halt  in  1  enter HALTED after the current cycle
resume  in  1  leave HALTED
pc  out  WIDTH  current fetch address
pc_plus1  out  WIDTH  pc + 1, modulo 2^WIDTH
fetch_valid  out  1  pc is a valid fetch address this cycle
ras_empty  out  1  RAS holds no entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_overflow  out  1  sticky: push occurred while full
ras_underflow  out  1  sticky: ret occurred while empty

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=BOOT, fetch_valid=0, RAS count=0, ras_empty=1, ras_full=0, both sticky flags=0. Release is synchronised by the clock edge only; no reset-release synchroniser inside.
- States: BOOT -> RUN unconditionally after one clk (pc stays RESET_PC, fetch_valid becomes 1 in RUN). RUN -> HALTED when halt=1 (pc is not updated on that edge). HALTED -> RUN when resume=1 (pc unchanged). In HALTED, fetch_valid=0 and all redirect inputs are ignored. halt and resume together in HALTED: resume wins. halt in BOOT is ignored.
- fetch_valid=1 only in RUN.
- pc_plus1 is combinational from pc; all-ones wraps to 0.
- Next-PC priority in RUN, evaluated at each rising edge: stall > ret > call > branch_taken > sequential (pc_plus1). stall=1 holds pc and RAS exactly, with no flag updates.
- call: pc <= branch_target; push pc_plus1. If the RAS is full, overwrite the oldest entry (circular), keep count at RAS_DEPTH and set ras_overflow.
- ret (with or without call): if the RAS is non-empty, pc <= top and pop. If it is empty, pc <= pc_plus1, count stays 0 and ras_underflow is set.
- call and ret in the same cycle: ret wins the PC. The RAS top is replaced with pc_plus1 and the count is unchanged, so a replace on full does not flag overflow. On empty the underflow rule applies and nothing is pushed.
- branch_taken together with call: identical to call.
- Sticky flags clear only on reset.
- RAS is implemented as a circular buffer with a top pointer and a count. ras_empty and ras_full are registered-count decodes, with no combinational path from inputs.
- Latency: every redirect takes effect on pc at the next edge. The block adds no bubbles; flush of fetched instructions is the pipeline's job.

Decomposition:
- Shared package: PC width constant, RESET_PC default, and the state encoding (BOOT=2'd0, RUN=2'd1, HALTED=2'd2).
- One sub-module is natural: ras_stack (push/pop/replace, count, top, full/empty, overflow/underflow pulses). The existing PC increment adder is instantiated for pc_plus1.

Test Plan:
- Reset then run 4 cycles: pc goes 0 (BOOT, fetch_valid=0), then 0, 1, 2, 3 with fetch_valid=1. Assert rst_n low mid-run: pc=0 immediately, without waiting for a clock edge.
- At pc=5, call with target 0x40; next cycle ret: pc goes 0x40 then 6, ras_empty returns to 1.
- 5 nested calls with RAS_DEPTH=4 from pcs 0x10, 0x20, 0x30, 0x40, 0x50: ras_overflow=1. Five rets give 0x51, 0x41, 0x31, 0x21, then underflow with pc=pc+1 and ras_underflow=1.
- Simultaneous call and ret at pc=7 with RAS top=0x100, target 0x200: pc=0x100, top becomes 8, count unchanged. stall asserted with call: pc and RAS unchanged.
- Set pc to 0xFFFF_FFFF via branch, then run sequentially: next pc=0, pc_plus1 wraps correctly.
- halt at pc=9: pc holds at 9 with fetch_valid=0, and branch_taken is ignored. resume: fetch_valid=1 at pc=9, then 10.
